// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern. Each
// qualified bit (data_valid=1) is appended to a history window. When the last
// PAT_W valid bits equal the pattern, a registered one-cycle flag is raised and
// a saturating match counter is advanced. Matching may be overlapping or
// non-overlapping (overlap_en, sampled only on the matching edge).
//
// Optional feature (compile-time macro SEQ_DETECT_MASK_EN):
//   adds input pat_mask_in and a mask register loaded with the pattern; only
//   bits whose mask bit is 1 take part in the compare. The mask resets to all
//   ones. Without the macro every pattern bit is compared.
//
// Parameters:
//   PAT_W    pattern length in bits (2..32)
//   PAT_INIT pattern loaded at reset, MSB is the first bit received
//   CNT_W    match counter width (1..32)
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   data_in      serial data bit
//   data_valid   data_in is sampled only when high
//   overlap_en   1 = overlapping matches, 0 = non-overlapping
//   pat_load     load pat_in (and pat_mask_in) as the new pattern
//   pat_in       new pattern, MSB is the first bit received
//   pat_mask_in  new compare mask (SEQ_DETECT_MASK_EN only)
//   cnt_clr      clear match_cnt (wins over a simultaneous match)
//   flag_out     registered one-cycle match pulse
//   match_cnt    saturating match count
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1101,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_W-1:0] pat_mask_in,
`endif
    input  logic             cnt_clr,
    output logic             flag_out,
    output logic [CNT_W-1:0] match_cnt
);

    // Fill counter only needs to reach PAT_W-1; PAT_W >= 2 keeps this >= 1 bit.
    localparam int                FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pat_reg,  pat_next;
    logic [PAT_W-2:0]  hist_reg, hist_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              match_next;

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  mask_eff;
    logic [PAT_W-1:0]  diff_bits;

`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_W-1:0]  mask_reg, mask_next;
    assign mask_eff = mask_reg;
`else
    assign mask_eff = {PAT_W{1'b1}};
`endif

    // Oldest valid bit sits at the MSB, matching the pattern's bit order.
    assign window = {hist_reg, data_in};

    // Per-bit disagreement, with don't-care positions forced to agree.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign diff_bits[gi] = (window[gi] ^ pat_reg[gi]) & mask_eff[gi];
        end
    endgenerate

    always_comb begin
        pat_next   = pat_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        match_next = 1'b0;
        cnt_next   = match_cnt;
`ifdef SEQ_DETECT_MASK_EN
        mask_next  = mask_reg;
`endif

        if (pat_load) begin
            // A bit presented alongside a load is dropped; history must refill.
            pat_next  = pat_in;
            fill_next = '0;
`ifdef SEQ_DETECT_MASK_EN
            mask_next = pat_mask_in;
`endif
        end else if (data_valid) begin
            match_next = (fill_reg == FILL_FULL) && (diff_bits == '0);
            hist_next  = window[PAT_W-2:0];
            if (match_next) begin
                // Overlapping keeps history "full" so the suffix can match again.
                fill_next = overlap_en ? FILL_FULL : '0;
            end else if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_W'(1);
            end
        end

        if (cnt_clr) begin
            cnt_next = '0;
        end else if (match_next && (match_cnt != CNT_MAX)) begin
            cnt_next = match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg   <= PAT_INIT;
            hist_reg  <= '0;
            fill_reg  <= '0;
            flag_out  <= 1'b0;
            match_cnt <= '0;
`ifdef SEQ_DETECT_MASK_EN
            mask_reg  <= {PAT_W{1'b1}};
`endif
        end else begin
            pat_reg   <= pat_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            flag_out  <= match_next;
            match_cnt <= cnt_next;
`ifdef SEQ_DETECT_MASK_EN
            mask_reg  <= mask_next;
`endif
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Two detectors share one stimulus stream: one with the default counter width
// and one with CNT_W=2 to exercise saturation. Expected flag and counts come
// from a reference model that keeps the valid bits since the last reset, load
// or non-overlapping match in a queue and compares the newest PAT_W of them
// with the pattern.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int PAT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_in;
    logic             data_valid;
    logic             overlap_en;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] pat_mask_in;
    logic             cnt_clr;

    logic             flag_a;
    logic [7:0]       cnt_a;
    logic             flag_b;
    logic [1:0]       cnt_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [PAT_W-1:0] m_pat;
    logic [PAT_W-1:0] m_mask;
    bit               m_q[$];
    bit               m_flag;
    int               m_cnt_a;
    int               m_cnt_b;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(PAT_W), .PAT_INIT(4'b1101), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
`ifdef SEQ_DETECT_MASK_EN
        .pat_mask_in(pat_mask_in),
`endif
        .cnt_clr    (cnt_clr),
        .flag_out   (flag_a),
        .match_cnt  (cnt_a)
    );

    seq_detect_param #(.PAT_W(PAT_W), .PAT_INIT(4'b1101), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .overlap_en (overlap_en),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
`ifdef SEQ_DETECT_MASK_EN
        .pat_mask_in(pat_mask_in),
`endif
        .cnt_clr    (cnt_clr),
        .flag_out   (flag_b),
        .match_cnt  (cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge.
    task automatic model_edge(input bit r, input bit d, input bit v, input bit ov,
                              input bit ld, input logic [PAT_W-1:0] pin,
                              input logic [PAT_W-1:0] min, input bit clr);
        logic [PAT_W-1:0] w;
        bit m;
        m = 1'b0;
        if (r) begin
            m_pat   = 4'b1101;
            m_mask  = '1;
            m_q.delete();
            m_flag  = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if (ld) begin
                m_pat = pin;
`ifdef SEQ_DETECT_MASK_EN
                m_mask = min;
`else
                m_mask = '1;
`endif
                m_q.delete();
            end else if (v) begin
                m_q.push_back(d);
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                if (m_q.size() == PAT_W) begin
                    w = '0;
                    foreach (m_q[i]) w = {w[PAT_W-2:0], m_q[i]};
                    m = (((w ^ m_pat) & m_mask) == '0);
                end
                if (m && !ov) m_q.delete();
            end
            m_flag = m;
            if (clr) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (m) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3)   m_cnt_b++;
            end
        end
    endtask

    // Drive one cycle, advance the model, then check both DUTs after the edge.
    task automatic cycle(input bit r, input bit d, input bit v, input bit ov,
                         input bit ld, input logic [PAT_W-1:0] pin,
                         input logic [PAT_W-1:0] min, input bit clr);
        rst         = r;
        data_in     = d;
        data_valid  = v;
        overlap_en  = ov;
        pat_load    = ld;
        pat_in      = pin;
        pat_mask_in = min;
        cnt_clr     = clr;
        model_edge(r, d, v, ov, ld, pin, min, clr);
        @(posedge clk);
        #1;
        cyc++;
        check_eq("flag_a", 32'(flag_a), 32'(m_flag));
        check_eq("flag_b", 32'(flag_b), 32'(m_flag));
        check_eq("cnt_a",  32'(cnt_a),  32'(m_cnt_a));
        check_eq("cnt_b",  32'(cnt_b),  32'(m_cnt_b));
        $display("cyc=%0d rst=%0b v=%0b d=%0b ov=%0b ld=%0b clr=%0b flag=%0b cnt=%0d cnt_sat=%0d",
                 cyc, r, v, d, ov, ld, clr, flag_a, cnt_a, cnt_b);
    endtask

    // Feed n valid bits, first bit taken from position n-1.
    task automatic feed(input logic [31:0] bits, input int n, input bit ov);
        for (int i = 0; i < n; i++)
            cycle(1'b0, bits[n-1-i], 1'b1, ov, 1'b0, '0, '1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0, '0, '1, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, '1, 1'b0);
    endtask

    initial begin
        // overlapping: pulses after bits 4 and 7
        do_reset();
        feed(32'b1101101, 7, 1'b1);
        check_eq("ovl_cnt", 32'(cnt_a), 32'd2);

        // non-overlapping: single pulse
        do_reset();
        feed(32'b1101101, 7, 1'b0);
        check_eq("novl_cnt", 32'(cnt_a), 32'd1);

        // gaps in data_valid do not break a partial match
        do_reset();
        feed(32'b110, 3, 1'b1);
        idle(3);
        feed(32'b1, 1, 1'b1);
        check_eq("gap_flag", 32'(flag_a), 32'd1);

        // pattern load mid-stream; bit on the load cycle is discarded
        do_reset();
        feed(32'b11, 2, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, '1, 1'b0);
        feed(32'b0110, 4, 1'b1);
        check_eq("load_flag", 32'(flag_a), 32'd1);

        // five overlapping matches: narrow counter saturates at 3
        do_reset();
        feed(32'b1101101101101101, 16, 1'b1);
        check_eq("sat_wide", 32'(cnt_a), 32'd5);
        check_eq("sat_narrow", 32'(cnt_b), 32'd3);
        // clear coinciding with a match: count 0, flag still pulses
        feed(32'b10, 2, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '1, 1'b1);
        check_eq("clr_flag", 32'(flag_a), 32'd1);
        check_eq("clr_cnt", 32'(cnt_a), 32'd0);

        // reset mid-stream discards partial history
        feed(32'b110, 3, 1'b1);
        do_reset();
        feed(32'b1, 1, 1'b1);
        check_eq("rst_noflag", 32'(flag_a), 32'd0);

`ifdef SEQ_DETECT_MASK_EN
        // masked compare: only MSB and LSB matter
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1001, 4'b1001, 1'b0);
        feed(32'b1001, 4, 1'b1);
        check_eq("mask_flag", 32'(flag_a), 32'd1);
`endif

        // randomized traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [PAT_W-1:0] rp;
            logic [PAT_W-1:0] rm;
            rp = PAT_W'($urandom_range(15));
`ifdef SEQ_DETECT_MASK_EN
            rm = PAT_W'($urandom_range(15));
`else
            rm = '1;
`endif
            cycle(($urandom_range(99) == 0),
                  1'($urandom_range(1)),
                  ($urandom_range(3) != 0),
                  1'($urandom_range(1)),
                  ($urandom_range(31) == 0),
                  rp, rm,
                  ($urandom_range(31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
